// File: rtl/button_debouncer_1k_if.sv
// Button debouncer bus: raw inputs and the 1 kHz square wave in,
// debounced levels, press pulses and the ms tick out.
interface button_debouncer_1k_if #(
  parameter int N_BTN = 4
);
  logic             clk_k;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             tick_ms;

  // Producer of the raw buttons and of clk_k (board / divider side)
  modport master (
    output clk_k,
    output btn_in,
    input  btn_level,
    input  btn_pulse,
    input  tick_ms
  );

  // The debouncer itself
  modport slave (
    input  clk_k,
    input  btn_in,
    output btn_level,
    output btn_pulse,
    output tick_ms
  );
endinterface

// File: rtl/button_debouncer_1k.sv
// Push-button debouncer and press detector for the RTC controller.
// clk_k (1 kHz from the divider) is synchronized and edge-detected into a
// one-cycle ms tick; every button is synchronized and must hold a new level
// for DEBOUNCE_TICKS consecutive ticks before the level is accepted.
// Accepted 0->1 transitions raise a one-cycle press pulse.
module button_debouncer_1k #(
  parameter int N_BTN          = 4,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  button_debouncer_1k_if.slave     bus
);

  // Counter only needs to reach DEBOUNCE_TICKS-1; keep at least one bit
  // so DEBOUNCE_TICKS = 1 still elaborates.
  localparam int            CW      = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

  // ---------------------------------------------------------------------
  // ms tick: clk_k is data, so synchronize it and detect its rising edge
  // ---------------------------------------------------------------------
  logic k1_q, k1_d;
  logic k2_q, k2_d;
  logic k3_q, k3_d;
  logic tick;

  // Next state of the clk_k synchronizer and edge-delay flop
  always_comb begin
    k1_d = bus.clk_k;
    k2_d = k1_q;
    k3_d = k2_q;
  end

  // clk_k synchronizer and delay registers
  always_ff @(posedge clk) begin
    if (reset) begin
      k1_q <= 1'b0;
      k2_q <= 1'b0;
      k3_q <= 1'b0;
    end else begin
      k1_q <= k1_d;
      k2_q <= k2_d;
      k3_q <= k3_d;
    end
  end

  // Rising edge of the synchronized clk_k; all registers are 0 in reset,
  // so the tick is 0 there too.
  assign tick        = k2_q & ~k3_q;
  assign bus.tick_ms = tick;

  // ---------------------------------------------------------------------
  // Button synchronizers (two flops per bit, shared vector)
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] b1_q, b1_d;
  logic [N_BTN-1:0] b2_q, b2_d;

  // Next state of the button synchronizer chain
  always_comb begin
    b1_d = bus.btn_in;
    b2_d = b1_q;
  end

  // Button synchronizer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      b1_q <= b1_d;
      b2_q <= b2_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-button debounce: independent counter, level and pulse per bit
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          pulse_q, pulse_d;

      // Debounce decision, evaluated only on ms ticks; pulse defaults low
      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (tick) begin
          if (b2_q[gi] == level_q) begin
            // Sample agrees with the accepted level: any run is broken
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            // This is the DEBOUNCE_TICKS-th consecutive differing sample
            level_d = b2_q[gi];
            pulse_d = b2_q[gi];
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Debounce state registers for this button
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
          pulse_q <= pulse_d;
        end
      end

      assign bus.btn_level[gi] = level_q;
      assign bus.btn_pulse[gi] = pulse_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer_1k.sv
// Self-checking bench for button_debouncer_1k (N_BTN = 4, DEBOUNCE_TICKS = 4,
// clk_k period = 10 clk). A behavioural model derives the expected outputs
// from sync delays and "DEBOUNCE_TICKS consecutive differing tick samples".
module tb_button_debouncer_1k;
  localparam int N  = 4;
  localparam int DT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  button_debouncer_1k_if #(.N_BTN(N)) bus ();

  button_debouncer_1k #(
    .N_BTN          (N),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  // ---------------- clk_k: 10-clk square wave, changes #1 after posedge
  int ck_phase = 0;
  initial begin
    bus.clk_k = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ck_phase  = (ck_phase + 1) % 10;
      bus.clk_k = (ck_phase < 5);
    end
  end

  // ---------------- behavioural model
  // since: clk edges since the most recent reset edge (saturates at 3).
  // A value synchronized through d flops is visible only once since >= d.
  int          since   = 0;
  logic        started = 1'b0;
  logic [2:0]  h_ck    = '0;            // [0]=this edge, [1]=one edge ago, [2]=two ago
  logic [N-1:0] h_btn0 = '0, h_btn1 = '0;
  logic        exp_tick  = 1'b0;
  logic [N-1:0] exp_b2    = '0;
  logic [N-1:0] exp_level = '0;
  logic [N-1:0] exp_pulse = '0;
  int          run [N];                 // consecutive tick samples differing from level

  always @(posedge clk) begin
    logic        tick_prev;
    logic [N-1:0] b2_prev;
    logic        k2, k3;
    tick_prev = exp_tick;
    b2_prev   = exp_b2;
    h_ck      = {h_ck[1:0], bus.clk_k};
    h_btn1    = h_btn0;
    h_btn0    = bus.btn_in;
    if (reset) begin
      started   = 1'b1;
      since     = 0;
      exp_tick  = 1'b0;
      exp_b2    = '0;
      exp_level = '0;
      exp_pulse = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      since     = (since < 3) ? since + 1 : 3;
      exp_pulse = '0;
      if (tick_prev) begin
        for (int i = 0; i < N; i++) begin
          if (b2_prev[i] != exp_level[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == DT) begin
              exp_level[i] = b2_prev[i];
              exp_pulse[i] = b2_prev[i];
              run[i]       = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      k2       = (since >= 2) ? h_ck[1] : 1'b0;
      k3       = (since >= 3) ? h_ck[2] : 1'b0;
      exp_tick = k2 & ~k3;
      exp_b2   = (since >= 2) ? h_btn1 : '0;
    end
  end

  // ---------------- per-cycle compare against the model
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (started) begin
      n_tests++;
      if (bus.tick_ms !== exp_tick) begin
        n_failed++;
        $display("FAIL tick_ms cyc=%0d: got %b expected %b", cyc, bus.tick_ms, exp_tick);
      end
      n_tests++;
      if (bus.btn_level !== exp_level) begin
        n_failed++;
        $display("FAIL btn_level cyc=%0d: got %b expected %b", cyc, bus.btn_level, exp_level);
      end
      n_tests++;
      if (bus.btn_pulse !== exp_pulse) begin
        n_failed++;
        $display("FAIL btn_pulse cyc=%0d: got %b expected %b", cyc, bus.btn_pulse, exp_pulse);
      end
    end
  end

  // ---------------- observation counters for literal checks
  int pulse_cnt [N];
  int sim_cnt  = 0;   // cycles with btn_pulse == 4'b1010
  int any_cnt  = 0;   // cycles with any pulse
  int tick_cnt = 0;   // DUT tick_ms pulses seen
  always @(negedge clk) begin
    if (started && !reset) begin
      for (int i = 0; i < N; i++) if (bus.btn_pulse[i] === 1'b1) pulse_cnt[i]++;
      if (bus.btn_pulse === 4'b1010) sim_cnt++;
      if (bus.btn_pulse !== 4'b0000) any_cnt++;
      if (bus.tick_ms === 1'b1) tick_cnt++;
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    sim_cnt  = 0;
    any_cnt  = 0;
    tick_cnt = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end else begin
      $display("[TB] %s ok: %0d", name, got);
    end
  endtask

  // Wait for n model ticks, returning on the negedge just after the n-th.
  task automatic wait_ticks(input int n);
    int seen = 0;
    int c    = 0;
    while (seen < n && c < 50 * n) begin
      @(negedge clk);
      c++;
      if (exp_tick) seen++;
    end
    if (seen < n) begin
      n_tests++;
      n_failed++;
      $display("FAIL tick_timeout: got %0d ticks expected %0d", seen, n);
    end
  endtask

  // ---------------- stimulus
  initial begin
    bus.btn_in = 4'hF;
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;

    // Reset behaviour: outputs held at 0 while reset with buttons high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs_zero", {bus.btn_level, bus.btn_pulse, 7'd0, bus.tick_ms}, 32'd0);
    end
    reset      = 1'b0;
    bus.btn_in = 4'h0;
    repeat (10) @(negedge clk);
    clear_counts();
    repeat (100) @(negedge clk);
    check("ticks_per_100_cycles", tick_cnt, 10);

    // Clean press on button 0
    wait_ticks(1);
    bus.btn_in = 4'b0001;
    clear_counts();
    wait_ticks(3);
    @(negedge clk);
    check("press0_level_after_3_ticks", bus.btn_level[0], 0);
    wait_ticks(1);
    @(negedge clk);
    check("press0_level_after_4_ticks", bus.btn_level[0], 1);
    wait_ticks(2);
    check("press0_pulse_count", pulse_cnt[0], 1);
    check("press0_other_pulses", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
    check("press0_level_vector", bus.btn_level, 4'b0001);

    // Bounce on button 1: 3 ticks high, 1 low, then steady high
    clear_counts();
    bus.btn_in = 4'b0011;
    wait_ticks(3);
    bus.btn_in = 4'b0001;
    wait_ticks(1);
    bus.btn_in = 4'b0011;
    wait_ticks(3);
    @(negedge clk);
    check("bounce1_level_after_3_ticks", bus.btn_level[1], 0);
    wait_ticks(1);
    @(negedge clk);
    check("bounce1_level_after_4_ticks", bus.btn_level[1], 1);
    wait_ticks(2);
    check("bounce1_pulse_count", pulse_cnt[1], 1);

    // Release of button 0: level falls after 4 ticks, no pulse
    clear_counts();
    bus.btn_in = 4'b0010;
    wait_ticks(3);
    @(negedge clk);
    check("release0_level_after_3_ticks", bus.btn_level[0], 1);
    wait_ticks(1);
    @(negedge clk);
    check("release0_level_after_4_ticks", bus.btn_level[0], 0);
    wait_ticks(2);
    check("release0_pulse_count", pulse_cnt[0], 0);

    // Simultaneous press of buttons 1 and 3 from an all-released state
    bus.btn_in = 4'b0000;
    wait_ticks(6);
    clear_counts();
    bus.btn_in = 4'b1010;
    wait_ticks(6);
    check("simul_pulse_1010_cycles", sim_cnt, 1);
    check("simul_any_pulse_cycles", any_cnt, 1);
    check("simul_level", bus.btn_level, 4'b1010);

    // Mid-operation reset: partial run of button 2 is discarded
    bus.btn_in = 4'b0000;
    wait_ticks(6);
    bus.btn_in = 4'b0100;
    wait_ticks(2);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(3);
    @(negedge clk);
    check("midreset_level_after_3_ticks", bus.btn_level[2], 0);
    wait_ticks(1);
    @(negedge clk);
    check("midreset_level_after_4_ticks", bus.btn_level[2], 1);

    // Randomized phase: sparse random bounces plus occasional resets
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) bus.btn_in[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 99) < 2) bus.btn_in = 4'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
